// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, packs bytes into DATA_W-bit words,
// checks the Ethernet FCS and delivers frames through a FWFT FIFO stream.
module rmii_rx_framer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int MIN_BYTES  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          rxd,
  input  logic                crs_dv,
  input  logic                speed_10,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_last,
  output logic                m_err,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt
);

  localparam int BYTES  = DATA_W / 8;
  localparam int FILL_W = $clog2(BYTES + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FW     = DATA_W + BYTES + 2;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_FLUSH, S_DISCARD} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                speed_reg, speed_next;
  logic [1:0]          phase_reg, phase_next;
  logic [5:0]          sh_reg, sh_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [31:0]         crc_reg, crc_next;
  logic [15:0]         byte_cnt_reg, byte_cnt_next;
  logic                odd_reg, odd_next;
  logic                ovf_reg, ovf_next;
  logic [15:0]         frame_cnt_reg, frame_cnt_next;
  logic [15:0]         drop_cnt_reg, drop_cnt_next;

  logic [AW:0]         wr_ptr_reg, rd_ptr_reg;
  logic [FW-1:0]       mem [FIFO_DEPTH];
  logic [FW-1:0]       wr_word, rd_word;
  logic                wr_en, rd_en, fifo_full, fifo_empty, can_write;

  logic                strobe, last_err;
  logic [7:0]          byte_v;
  logic [BYTES-1:0]    fill_keep;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_keep
      assign fill_keep[gi] = (fill_reg > FILL_W'(gi));
    end
  endgenerate

  // In IDLE the live speed input picks the strobe rate; afterwards the latched one.
  assign strobe = ((state_reg == S_IDLE) ? speed_10 : speed_reg) ? (cnt_reg == 4'd0) : 1'b1;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_en      = !fifo_empty && m_ready;
  assign can_write  = !fifo_full || rd_en;
  assign last_err   = (crc_reg != CRC_RESIDUE) || (byte_cnt_reg < 16'(MIN_BYTES)) ||
                      odd_reg || ovf_reg;

  always_comb begin
    state_next     = state_reg;
    speed_next     = speed_reg;
    phase_next     = phase_reg;
    sh_next        = sh_reg;
    acc_next       = acc_reg;
    fill_next      = fill_reg;
    crc_next       = crc_reg;
    byte_cnt_next  = byte_cnt_reg;
    odd_next       = odd_reg;
    ovf_next       = ovf_reg;
    frame_cnt_next = frame_cnt_reg;
    drop_cnt_next  = drop_cnt_reg;
    wr_en          = 1'b0;
    wr_word        = '0;
    byte_v         = {rxd, sh_reg};

    case (state_reg)
      S_IDLE: begin
        if (strobe && crs_dv && rxd == 2'b01) begin
          state_next = S_PREAMBLE;
          speed_next = speed_10;
        end
      end
      S_PREAMBLE: begin
        if (strobe) begin
          if (!crs_dv) begin
            state_next = S_IDLE;
          end else if (rxd == 2'b11) begin
            state_next    = S_DATA;
            phase_next    = 2'd0;
            acc_next      = '0;
            fill_next     = '0;
            crc_next      = 32'hFFFFFFFF;
            byte_cnt_next = 16'd0;
            odd_next      = 1'b0;
            ovf_next      = 1'b0;
          end else if (rxd != 2'b01) begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          if (!crs_dv) begin
            odd_next   = (phase_reg != 2'd0);
            state_next = S_FLUSH;
          end else begin
            // A full word is held until the next strobe so that a frame ending
            // on a word boundary closes with that word as its last beat.
            if (fill_reg == FILL_W'(BYTES)) begin
              if (can_write) begin
                wr_en     = 1'b1;
                wr_word   = {acc_reg, {BYTES{1'b1}}, 1'b0, 1'b0};
                acc_next  = '0;
                fill_next = '0;
              end else begin
                ovf_next      = 1'b1;
                drop_cnt_next = drop_cnt_reg + 16'd1;
                state_next    = S_DISCARD;
              end
            end
            if (state_next == S_DATA) begin
              phase_next = phase_reg + 2'd1;
              sh_next    = {rxd, sh_reg[5:2]};
              if (phase_reg == 2'd3) begin
                crc_next      = crc_byte(crc_reg, byte_v);
                byte_cnt_next = byte_cnt_reg + {15'd0, ~&byte_cnt_reg};
                fill_next     = fill_reg + FILL_W'(1);
                for (int i = 0; i < BYTES; i++) begin
                  if (fill_reg == FILL_W'(i)) acc_next[i*8 +: 8] = byte_v;
                end
              end
            end
          end
        end
      end
      S_DISCARD: begin
        if (strobe && !crs_dv) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        wr_word = {acc_reg, (ovf_reg ? {BYTES{1'b0}} : fill_keep), 1'b1, last_err};
        if (can_write) begin
          wr_en      = 1'b1;
          state_next = S_IDLE;
          if (!last_err) frame_cnt_next = frame_cnt_reg + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_reg == S_IDLE && state_next == S_PREAMBLE) cnt_next = 4'd0;
    else cnt_next = (cnt_reg == 4'd9) ? 4'd0 : cnt_reg + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      speed_reg     <= 1'b0;
      phase_reg     <= 2'd0;
      sh_reg        <= 6'd0;
      acc_reg       <= '0;
      fill_reg      <= '0;
      crc_reg       <= 32'hFFFFFFFF;
      byte_cnt_reg  <= 16'd0;
      odd_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      frame_cnt_reg <= 16'd0;
      drop_cnt_reg  <= 16'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      speed_reg     <= speed_next;
      phase_reg     <= phase_next;
      sh_reg        <= sh_next;
      acc_reg       <= acc_next;
      fill_reg      <= fill_next;
      crc_reg       <= crc_next;
      byte_cnt_reg  <= byte_cnt_next;
      odd_reg       <= odd_next;
      ovf_reg       <= ovf_next;
      frame_cnt_reg <= frame_cnt_next;
      drop_cnt_reg  <= drop_cnt_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_word;
  end

  // Storage is never reset, so the head word is masked whenever the FIFO is empty.
  assign rd_word   = mem[rd_ptr_reg[AW-1:0]];
  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? rd_word[FW-1 -: DATA_W] : '0;
  assign m_keep    = m_valid ? rd_word[BYTES+1:2] : '0;
  assign m_last    = m_valid ? rd_word[1] : 1'b0;
  assign m_err     = m_valid ? rd_word[0] : 1'b0;
  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule
